// File: rtl/memref_port_arbiter.sv
// memref_port_arbiter: round-robin share of one single-port memref
// between two requesters, with read-return routing and a contention counter.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   rX_en/wr/addr/wr_data       requester X access request (X = 0, 1)
//   rX_gnt                      requester X accepted this cycle
//   rX_rd_valid/rd_data         read return for requester X
//   mem_addr/rd_en/wr_en/
//   mem_wr_data/mem_rd_data     memory side, 1-cycle registered read
//   conflict_count              saturating count of cycles with both en high
module memref_port_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_en,
  input  logic                  r0_wr,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wr_data,
  output logic                  r0_gnt,
  output logic                  r0_rd_valid,
  output logic [DATA_WIDTH-1:0] r0_rd_data,
  input  logic                  r1_en,
  input  logic                  r1_wr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wr_data,
  output logic                  r1_gnt,
  output logic                  r1_rd_valid,
  output logic [DATA_WIDTH-1:0] r1_rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [CNT_WIDTH-1:0]  conflict_count
);

  logic                 r_last_gnt;
  logic                 r_rd_pend;
  logic                 r_rd_id;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic w_req0;
  logic w_req1;
  logic w_g0;
  logic w_g1;
  logic w_any;
  logic w_wr;
  logic w_conf;
  logic w_v0;
  logic w_v1;

  // Requests are masked while in reset so nothing reaches memory.
  assign w_req0 = ~rst & r0_en;
  assign w_req1 = ~rst & r1_en;

  // r1 wins when alone, or on a tie if r0 was granted last.
  assign w_g1  = w_req1 & (~w_req0 | ~r_last_gnt);
  assign w_g0  = w_req0 & ~w_g1;
  assign w_any = w_g0 | w_g1;

  // AND-OR muxing keeps X on the idle port away from memory.
  assign w_wr = (w_g0 & r0_wr) | (w_g1 & r1_wr);

  assign r0_gnt    = w_g0;
  assign r1_gnt    = w_g1;
  assign mem_wr_en = w_any & w_wr;
  assign mem_rd_en = w_any & ~w_wr;

  assign mem_addr =
    ({ADDR_WIDTH{w_g0}} & r0_addr) |
    ({ADDR_WIDTH{w_g1}} & r1_addr);

  assign mem_wr_data =
    ({DATA_WIDTH{w_g0}} & r0_wr_data) |
    ({DATA_WIDTH{w_g1}} & r1_wr_data);

  assign w_conf = r0_en & r1_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_id    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_any) begin
        r_last_gnt <= w_g1;
      end
      r_rd_pend <= mem_rd_en;
      if (mem_rd_en) begin
        r_rd_id <= w_g1;
      end
      if (w_conf && !(&r_cnt)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A read pending across a rising reset is dropped.
  assign w_v0 = ~rst & r_rd_pend & ~r_rd_id;
  assign w_v1 = ~rst & r_rd_pend & r_rd_id;

  assign r0_rd_valid = w_v0;
  assign r1_rd_valid = w_v1;
  assign r0_rd_data  = {DATA_WIDTH{w_v0}} & mem_rd_data;
  assign r1_rd_data  = {DATA_WIDTH{w_v1}} & mem_rd_data;

  assign conflict_count = r_cnt;

endmodule

// File: doc/memref_port_arbiter.md
Name: memref_port_arbiter

Overview:
- Shares one single-port memref (e.g. the 8x32 Y or tmp buffer) between two kernel-side requesters. Uses round-robin arbitration with a grant handshake.
- Sits between kernel memref ports and the memref_rd/memref_wr-style RAM model, or a BRAM with 1-cycle registered read.
- Routes read data back to the requester that issued the read.
- Counts contention cycles for performance comparison between scheduled (HIR) and HLS kernels.

Parameters:
- ADDR_WIDTH, 3, memref address width (8 entries).
- DATA_WIDTH, 32, element width.
- CNT_WIDTH, 16, width of the saturating contention counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- r0_en  input  1  requester 0 access request; held until granted.
- r0_wr  input  1  1 = write, 0 = read; qualified by r0_en.
- r0_addr  input  ADDR_WIDTH  requester 0 address.
- r0_wr_data  input  DATA_WIDTH  requester 0 write data.
- r0_gnt  output  1  access accepted this cycle (combinational).
- r0_rd_valid  output  1  read data valid for requester 0.
- r0_rd_data  output  DATA_WIDTH  read data for requester 0.
- r1_en, r1_wr, r1_addr, r1_wr_data, r1_gnt, r1_rd_valid, r1_rd_data  same as requester 0, for requester 1.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_rd_en  output  1  memory read enable.
- mem_wr_en  output  1  memory write enable.
- mem_wr_data  output  DATA_WIDTH  memory write data.
- mem_rd_data  input  DATA_WIDTH  memory read data, valid 1 cycle after mem_rd_en.
- conflict_count  output  CNT_WIDTH  number of cycles in which both requesters asserted en.

Behaviour:
- Arbitration (combinational, same cycle):
  - Only r0_en asserted -> r0 wins.
  - Only r1_en asserted -> r1 wins.
  - Both asserted -> the requester not granted most recently wins.
  - Neither asserted -> no grant; mem_rd_en = mem_wr_en = 0.
- State register last_gnt (1 bit):
  - Reset value 1, so r0 wins the first tie after reset.
  - Updated to the winner's id on every grant; unchanged when idle.
- Memory drive:
  - mem_addr and mem_wr_data are muxed from the winner.
  - mem_wr_en = winner en & wr; mem_rd_en = winner en & ~wr.
  - With no winner, mem_addr and mem_wr_data are 0.
- Exactly one rX_gnt is high at most; the loser sees gnt = 0 and must hold its request unchanged.
- Read return path:
  - rd_pend (1 bit) and rd_id (1 bit) register the winner of a granted read.
  - In the next cycle, r<rd_id>_rd_valid = 1 and r<rd_id>_rd_data = mem_rd_data.
  - The other requester's rd_valid is 0 and its rd_data is 0.
  - Read latency is 1 cycle from grant; back-to-back reads give one valid per cycle.
- Write: takes effect at the granting edge; no response signal. A read of the same address in the next cycle returns the new data.
- Alternating fairness: under continuous contention, grants alternate r0, r1, r0, ... A requester therefore waits at most 1 cycle.
- conflict_count:
  - Increments by 1 on each cycle with r0_en & r1_en.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Cleared only by rst.
- Reset (synchronous):
  - last_gnt = 1; rd_pend = 0; rd_id = 0; conflict_count = 0.
  - While rst is high, all gnt, mem_rd_en and mem_wr_en are 0, regardless of en.
  - A read granted in the cycle before rst rises produces no rd_valid (rd_pend cleared).
  - The first grant can occur in the first cycle rst is low.
- X on en, wr or addr of a non-requesting port must not propagate to the memory outputs.

Test Plan:
- Memory preloaded with mem[i] = i+1. r0 reads addr 5 alone -> r0_gnt = 1 the same cycle; next cycle r0_rd_valid = 1, r0_rd_data = 6; r1_rd_valid = 0; conflict_count = 0.
- After reset, r0 reads addr 2 and r1 reads addr 3 simultaneously, both holding -> cycle 0 grants r0, cycle 1 grants r1. r0_rd_data = 3 at cycle 1; r1_rd_data = 4 at cycle 2; conflict_count = 1.
- Both hold reads for 6 cycles -> grant sequence r0, r1, r0, r1, r0, r1; conflict_count = 6; every rd_valid routed to the correct id.
- r1 writes 0xDEAD to addr 7, then r0 reads addr 7 the next cycle -> r0_rd_data = 0xDEAD; mem_wr_en high exactly 1 cycle.
- r0 read granted at cycle N, rst high at cycle N+1 -> no rd_valid at N+1. After release: last_gnt = 1, conflict_count = 0, and the next tie grants r0.
- CNT_WIDTH = 3 with continuous contention for 10 cycles -> conflict_count = 7, stays at 7.
